endec_frame_io: RTL

Word-stream front end for the convolutional encoder/Viterbi decoder core. Packs a 32-bit input stream into a 128-bit encode frame or a 384-bit decode frame and runs the core. The core is enabled until its done flag, then the result is serialised back out as 32-bit words. It chains encoder state across consecutive encode frames of one message and recovers from a hung core with a timeout.

---
 rtl/endec_frame_io_pkg.sv | 24 ++
 rtl/endec_frame_io_word_serializer.sv | 40 ++++
 rtl/endec_frame_io.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/endec_frame_io_pkg.sv
// Shared types and constants for the encoder/decoder frame front end.
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 6
`endif

package endec_frame_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } frame_state_e;

    localparam int ENC_FRAME_W = 128;
    localparam int DEC_FRAME_W = 384;
    localparam int STATE_W     = `MAX_STATE_REG_NUM;

    // Number of stream words needed to cover a frame of the given width.
    function automatic int words_of(input int frame_w, input int word_w);
        return frame_w / word_w;
    endfunction

endpackage

// File: rtl/endec_frame_io_word_serializer.sv
// Loads a result frame and shifts it out one word per valid/ready transfer,
// lowest word first, for a caller-supplied number of words.
module endec_frame_io_word_serializer #(
    parameter int WORD_W  = 32,
    parameter int FRAME_W = 384,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic [CNT_W-1:0]   load_count,
    output logic [WORD_W-1:0]  o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last
);

    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   left_q;

    assign o_valid = (left_q != '0);
    assign o_data  = shift_q[WORD_W-1:0];
    assign o_last  = o_valid && i_ready && (left_q == CNT_W'(1));

    // Shift register and remaining-word count; data only moves on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            left_q  <= '0;
        end else if (load) begin
            shift_q <= load_data;
            left_q  <= load_count;
        end else if (o_valid && i_ready) begin
            shift_q <= shift_q >> WORD_W;
            left_q  <= left_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/endec_frame_io.sv
// Word-stream front end: packs input words into an encode/decode frame,
// runs the core until done (or timeout), then serialises the result.
//
// state | meaning
// IDLE  | waiting for first word of a frame; latches mode, rate, sof
// LOAD  | collecting remaining frame words
// RUN   | core enabled, waiting for the done flag of the latched mode
// DRAIN | result words streaming out
module endec_frame_io
    import endec_frame_io_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          i_mode,
    input  logic                          i_code_rate,
    input  logic                          i_sof,
    input  logic [WORD_W-1:0]             i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [WORD_W-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_en,
    output logic                          o_code_rate,
    output logic [ENC_FRAME_W-1:0]        o_encoder_data_frame,
    output logic [DEC_FRAME_W-1:0]        o_decoder_data_frame,
    output logic [`MAX_STATE_REG_NUM-1:0] o_prv_encoder_state,
    input  logic [DEC_FRAME_W-1:0]        i_encoder_data,
    input  logic                          i_encoder_done,
    input  logic [ENC_FRAME_W-1:0]        i_decoder_data,
    input  logic                          i_decoder_done,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int ENC_IN_WORDS  = words_of(ENC_FRAME_W, WORD_W);
    localparam int DEC_IN_WORDS  = words_of(DEC_FRAME_W, WORD_W);
    localparam int ENC_OUT_WORDS = words_of(DEC_FRAME_W, WORD_W);
    localparam int DEC_OUT_WORDS = words_of(ENC_FRAME_W, WORD_W);
    localparam int IDX_W         = $clog2(DEC_IN_WORDS + 1);
    localparam int TO_W          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    frame_state_e       state_q, state_d;
    logic               mode_q;
    logic               rate_q;
    logic [DEC_FRAME_W-1:0] frame_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [STATE_W-1:0] chain_q;
    logic               err_q;

    logic [IDX_W-1:0]   first_last;
    logic [IDX_W-1:0]   load_last;
    logic               done_hit;
    logic               timeout_hit;
    logic               ser_last;
    logic [DEC_FRAME_W-1:0] ser_data;
    logic [IDX_W-1:0]   ser_count;

    assign first_last  = i_mode ? IDX_W'(DEC_IN_WORDS - 1) : IDX_W'(ENC_IN_WORDS - 1);
    assign load_last   = mode_q ? IDX_W'(DEC_IN_WORDS - 1) : IDX_W'(ENC_IN_WORDS - 1);
    assign done_hit    = (state_q == RUN) && (mode_q ? i_decoder_done : i_encoder_done);
    assign timeout_hit = (state_q == RUN) && !done_hit && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    assign ser_data  = mode_q ? DEC_FRAME_W'(i_decoder_data) : i_encoder_data;
    assign ser_count = mode_q ? IDX_W'(DEC_OUT_WORDS) : IDX_W'(ENC_OUT_WORDS);

    assign o_code_rate          = rate_q;
    assign o_encoder_data_frame = mode_q ? '0 : frame_q[ENC_FRAME_W-1:0];
    assign o_decoder_data_frame = mode_q ? frame_q : '0;
    assign o_prv_encoder_state  = chain_q;
    assign o_err                = err_q;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and state-decoded handshake/enable outputs.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_en    = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) state_d = (first_last == '0) ? RUN : LOAD;
            end
            LOAD: begin
                o_ready = 1'b1;
                if (i_valid && (idx_q == load_last)) state_d = RUN;
            end
            RUN: begin
                o_en = 1'b1;
                if (done_hit)         state_d = DRAIN;
                else if (timeout_hit) state_d = IDLE;
            end
            DRAIN: begin
                if (ser_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame assembly, latched controls, chained encoder state, timeout counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            rate_q   <= 1'b0;
            frame_q  <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            chain_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && i_valid) begin
                mode_q  <= i_mode;
                rate_q  <= i_code_rate;
                frame_q <= DEC_FRAME_W'(i_data);
                idx_q   <= IDX_W'(1);
                // Decode frames leave the encoder chain alone even when sof is set.
                if (i_sof && !i_mode) chain_q <= '0;
            end else if (state_q == LOAD && i_valid) begin
                frame_q[int'(idx_q) * WORD_W +: WORD_W] <= i_data;
                idx_q <= idx_q + IDX_W'(1);
            end
            if (done_hit && !mode_q) chain_q <= frame_q[STATE_W-1:0];
            if (timeout_hit) frame_q <= '0;
            to_cnt_q <= (state_q == RUN) ? to_cnt_q + TO_W'(1) : '0;
            err_q    <= timeout_hit;
        end
    end

    endec_frame_io_word_serializer #(
        .WORD_W  (WORD_W),
        .FRAME_W (DEC_FRAME_W),
        .CNT_W   (IDX_W)
    ) u_serializer (
        .clk        (sys_clk),
        .rst        (rst),
        .load       (done_hit),
        .load_data  (ser_data),
        .load_count (ser_count),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (ser_last)
    );

endmodule
